traffic_fsm: RTL and testbench
==============================

TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 SHALL have parameter DEF_BASE, default 4'd6: reset value of the base interval (seconds).
REQ-002 SHALL have parameter DEF_EXT, default 4'd3: reset value of the extended interval.
REQ-003 SHALL have parameter DEF_YEL, default 4'd2: reset value of the yellow interval.
REQ-004 SHALL have port clk  in  1: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port sys_reset  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port sensor  in  1: side-road vehicle present, level, synchronous to clk.
REQ-007 SHALL have port walk_push  in  1: pedestrian button, single-cycle or level.
REQ-008 SHALL have port reprogram  in  1: one-cycle strobe that writes time_value to the register selected by time_param_sel.
REQ-009 SHALL have port time_param_sel  in  2: 0 = base, 1 = ext, 2 = yel, 3 = no write.
REQ-010 SHALL have port time_value  in  4: new interval in seconds.
REQ-011 SHALL have port expired  in  1: one-cycle pulse from the Timer when the interval ends.
REQ-012 SHALL have port start_timer  out  1: one-cycle pulse that loads the Timer.
REQ-013 SHALL have port timer_value  out  4: interval for the current state; feeds the Timer input_value.
REQ-014 SHALL have port main_light  out  3: main-road lamps {R,Y,G}, one-hot.
REQ-015 SHALL have port side_light  out  3: side-road lamps {R,Y,G}, one-hot.
REQ-016 SHALL have port walk_lamp  out  1: pedestrian WALK indication.

Function
REQ-017 SHALL implement the states MG1, MG2, MY, WALK, SG1, SG2 and SY.
- Lamps: MG* = main G, side R; MY = main Y, side R; WALK = both R, walk_lamp=1; SG* = main R, side G; SY = main R, side Y.
REQ-018 SHALL use these transitions, taken only on an edge where expired=1:
- MG1 -> MY if sensor=1, else MG2.
- MG2 -> MY.
- MY -> WALK if walk_pend=1, else SG1.
- WALK -> SG1.
- SG1 -> SG2 if sensor=1, else SY.
- SG2 -> SY.
- SY -> MG1.
REQ-019 SHALL use these intervals: MG1, MG2 and SG1 = base; SG2 and WALK = ext; MY and SY = yel.
REQ-020 SHALL hold timer_value stable for the whole dwell in a state and drive it to the new state's interval in the cycle start_timer is asserted.
REQ-021 SHALL assert start_timer for exactly one cycle, registered, in the first cycle after each state entry; this includes the first cycle after sys_reset deasserts and the cycle after a restart.
REQ-022 SHALL ignore expired in any cycle where start_timer=1, because such a pulse is stale.
REQ-023 SHALL latch walk_push into walk_pend, clear walk_pend on entry to WALK, and re-set it if walk_push=1 during WALK so the request is served on the next cycle of the sequence.
REQ-024 SHALL handle reprogram with sel 0..2 and time_value != 0 as follows: write the register, force the state to MG1, and issue a start_timer pulse next cycle.
- time_value = 0 or sel = 3: no write and no restart.
REQ-025 SHALL give reprogram priority over a simultaneous expired; the written value is the one used for the new MG1 when sel = 0.
REQ-026 SHALL give sys_reset priority over reprogram, expired and walk_push.

Reset
REQ-027 SHALL set the following on sys_reset=1 at a clock edge:
- state = MG1, walk_pend = 0, start_timer = 0.
- base, ext, yel = DEF_BASE, DEF_EXT, DEF_YEL.
- main_light = G, side_light = R, walk_lamp = 0, timer_value = DEF_BASE.
REQ-028 SHALL apply reset mid-operation in any state with the same result and leave no residual pending start or walk request.

Structure
REQ-029 SHALL place the following in a shared package traffic_pkg: state encoding, lamp encodings {R,Y,G}, param-select codes, and default interval constants.
REQ-030 SHALL place the three interval registers, write decode and zero-rejection in one sub-module traffic_param_regs; the FSM, walk latch and start pulse stay in traffic_fsm.

Verification
REQ-031 SHALL cover reset with sensor=0 and no walk, using a behavioural Timer:
- Stimulus: release reset.
- Response: start_timer at cycle 1 with value 6; sequence MG1(6) -> MG2(6) -> MY(2) -> SG1(6) -> SY(2) -> MG1.
REQ-032 SHALL cover sensor=1 throughout:
- Response: MG1(6) -> MY(2) -> SG1(6) -> SG2(3) -> SY(2); MG2 never entered.
REQ-033 SHALL cover a walk request:
- Stimulus: walk_push pulse during MG1.
- Response: after MY comes WALK with walk_lamp=1 and timer_value=3, then SG1; walk_pend clear in the next cycle.
REQ-034 SHALL cover reprogramming:
- Stimulus: reprogram, sel=0, value=9 while in SG1, in the same cycle as expired.
- Response: next state MG1, start_timer next cycle, timer_value=9, SG2/SY skipped.
- Stimulus: value=0.
- Response: ignored, no restart.
REQ-035 SHALL cover reset in the middle of SG2:
- Response: all outputs match REQ-027 and a fresh start_timer one cycle after release.
REQ-036 SHALL cover a stale expired:
- Stimulus: expired pulsed in the same cycle as start_timer.
- Response: no state change.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg -- shared definitions for the traffic light controller.
//   state_e        : FSM state encoding (also exported on the debug port)
//   LAMP_*         : lamp encodings, bit order {R,Y,G}, one-hot
//   SEL_*          : time_param_sel codes
//   DEF_*_C        : default interval values in seconds
//   interval_for() : interval that belongs to a given state
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_MG1  = 3'd0,
    ST_MG2  = 3'd1,
    ST_MY   = 3'd2,
    ST_WALK = 3'd3,
    ST_SG1  = 3'd4,
    ST_SG2  = 3'd5,
    ST_SY   = 3'd6
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic [3:0] DEF_BASE_C = 4'd6;
  localparam logic [3:0] DEF_EXT_C  = 4'd3;
  localparam logic [3:0] DEF_YEL_C  = 4'd2;

  function automatic logic [3:0] interval_for(state_e s, logic [3:0] base,
                                              logic [3:0] ext, logic [3:0] yel);
    logic [3:0] r;
    case (s)
      ST_SG2, ST_WALK: r = ext;
      ST_MY, ST_SY:    r = yel;
      default:         r = base;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/traffic_param_regs.sv
// traffic_param_regs -- the three interval registers (base, ext, yel).
//   clk, sys_reset      : clock, synchronous active-high reset
//   reprogram           : one-cycle write strobe
//   time_param_sel      : register select (SEL_NONE = no write)
//   time_value          : value to write; zero is rejected
//   wr_accept           : this cycle's strobe is a real write (combinational)
//   base_nxt/ext_nxt/yel_nxt : register values as they will be after this
//                         edge, so a restart can load a freshly written value
module traffic_param_regs
  import traffic_pkg::*;
#(
  parameter logic [3:0] DEF_BASE = DEF_BASE_C,
  parameter logic [3:0] DEF_EXT  = DEF_EXT_C,
  parameter logic [3:0] DEF_YEL  = DEF_YEL_C
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       wr_accept,
  output logic [3:0] base_nxt,
  output logic [3:0] ext_nxt,
  output logic [3:0] yel_nxt
);

  logic [3:0] base_q, base_d;
  logic [3:0] ext_q, ext_d;
  logic [3:0] yel_q, yel_d;

  always_comb begin
    wr_accept = reprogram && (time_param_sel != SEL_NONE) && (time_value != 4'd0);
    base_d    = base_q;
    ext_d     = ext_q;
    yel_d     = yel_q;
    if (wr_accept) begin
      case (time_param_sel)
        SEL_BASE: base_d = time_value;
        SEL_EXT:  ext_d  = time_value;
        SEL_YEL:  yel_d  = time_value;
        default:  ;
      endcase
    end
  end

  assign base_nxt = base_d;
  assign ext_nxt  = ext_d;
  assign yel_nxt  = yel_d;

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      base_q <= DEF_BASE;
      ext_q  <= DEF_EXT;
      yel_q  <= DEF_YEL;
    end else begin
      base_q <= base_d;
      ext_q  <= ext_d;
      yel_q  <= yel_d;
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// traffic_fsm -- main/side road traffic light controller with pedestrian WALK.
//   clk, sys_reset       : clock, synchronous active-high reset
//   sensor               : side-road vehicle present (level)
//   walk_push            : pedestrian request, latched into walk_pend
//   reprogram, time_param_sel, time_value : interval register write port
//   expired              : end-of-interval pulse from the external Timer
//   start_timer          : registered one-cycle Timer load pulse
//   timer_value          : interval of the current state (Timer input_value)
//   main_light/side_light: lamps {R,Y,G}, one-hot
//   walk_lamp            : pedestrian WALK indication
//   dbg_state, dbg_walk_pend : current FSM state and pending walk request
//
// Timer protocol: start_timer is high for exactly the first cycle after a
// state is entered and timer_value already carries that state's interval in
// that cycle. The Timer answers with a one-cycle expired pulse; an expired
// seen while start_timer (or the post-reset load) is pending belongs to the
// previous interval and is dropped.
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter logic [3:0] DEF_BASE = DEF_BASE_C,
  parameter logic [3:0] DEF_EXT  = DEF_EXT_C,
  parameter logic [3:0] DEF_YEL  = DEF_YEL_C
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       sensor,
  input  logic       walk_push,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] timer_value,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_lamp,
  output logic [2:0] dbg_state,
  output logic       dbg_walk_pend
);

  state_e     state_q, state_d, succ_state;
  logic       walk_pend_q, walk_pend_d;
  logic       start_q, start_d;
  // Set during reset so the first cycle after release issues a Timer load.
  logic       fresh_q, fresh_d;
  logic [3:0] timer_value_q, timer_value_d;

  logic       wr_accept;
  logic [3:0] base_nxt, ext_nxt, yel_nxt;
  logic       exp_ok;

  traffic_param_regs #(
    .DEF_BASE(DEF_BASE),
    .DEF_EXT (DEF_EXT),
    .DEF_YEL (DEF_YEL)
  ) u_regs (
    .clk           (clk),
    .sys_reset     (sys_reset),
    .reprogram     (reprogram),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .wr_accept     (wr_accept),
    .base_nxt      (base_nxt),
    .ext_nxt       (ext_nxt),
    .yel_nxt       (yel_nxt)
  );

  // Successor of the current state when its interval ends.
  always_comb begin
    succ_state = ST_MG1;
    case (state_q)
      ST_MG1:  succ_state = sensor ? ST_MY : ST_MG2;
      ST_MG2:  succ_state = ST_MY;
      ST_MY:   succ_state = walk_pend_q ? ST_WALK : ST_SG1;
      ST_WALK: succ_state = ST_SG1;
      ST_SG1:  succ_state = sensor ? ST_SG2 : ST_SY;
      ST_SG2:  succ_state = ST_SY;
      ST_SY:   succ_state = ST_MG1;
      default: succ_state = ST_MG1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    walk_pend_d   = walk_pend_q | walk_push;
    start_d       = fresh_q;
    fresh_d       = 1'b0;
    timer_value_d = timer_value_q;
    exp_ok        = expired && !start_q && !fresh_q;
    if (wr_accept) begin
      state_d       = ST_MG1;
      start_d       = 1'b1;
      timer_value_d = base_nxt;
    end else if (exp_ok) begin
      state_d       = succ_state;
      start_d       = 1'b1;
      timer_value_d = interval_for(succ_state, base_nxt, ext_nxt, yel_nxt);
      // Entering WALK serves the request; a push in this same cycle re-arms it.
      if (succ_state == ST_WALK) walk_pend_d = walk_push;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q       <= ST_MG1;
      walk_pend_q   <= 1'b0;
      start_q       <= 1'b0;
      fresh_q       <= 1'b1;
      timer_value_q <= DEF_BASE;
    end else begin
      state_q       <= state_d;
      walk_pend_q   <= walk_pend_d;
      start_q       <= start_d;
      fresh_q       <= fresh_d;
      timer_value_q <= timer_value_d;
    end
  end

  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    walk_lamp  = 1'b0;
    case (state_q)
      ST_MG1, ST_MG2: main_light = LAMP_G;
      ST_MY:          main_light = LAMP_Y;
      ST_WALK:        walk_lamp  = 1'b1;
      ST_SG1, ST_SG2: side_light = LAMP_G;
      ST_SY:          side_light = LAMP_Y;
      default:        main_light = LAMP_G;
    endcase
  end

  assign start_timer   = start_q;
  assign timer_value   = timer_value_q;
  assign dbg_state     = state_q;
  assign dbg_walk_pend = walk_pend_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// tb_traffic_fsm -- directed bench for traffic_fsm with a behavioural Timer.
module tb_traffic_fsm;
  import traffic_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sys_reset = 1'b1;
  logic       sensor = 1'b0;
  logic       walk_push = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_sel = 2'd3;
  logic [3:0] time_value = 4'd0;
  logic       man_exp = 1'b0;
  logic       expired;
  logic       start_timer;
  logic [3:0] timer_value;
  logic [2:0] main_light, side_light, dbg_state;
  logic       walk_lamp, dbg_walk_pend;

  traffic_fsm dut (
    .clk           (clk),
    .sys_reset     (sys_reset),
    .sensor        (sensor),
    .walk_push     (walk_push),
    .reprogram     (reprogram),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .expired       (expired),
    .start_timer   (start_timer),
    .timer_value   (timer_value),
    .main_light    (main_light),
    .side_light    (side_light),
    .walk_lamp     (walk_lamp),
    .dbg_state     (dbg_state),
    .dbg_walk_pend (dbg_walk_pend)
  );

  // ---------------- behavioural Timer ----------------
  // Loads on start_timer, pulses expired N+1 edges later, so the FSM sees
  // consecutive start pulses N+2 cycles apart.
  logic [3:0] tmr_cnt = 4'd0;
  logic       tmr_run = 1'b0;
  logic       tmr_exp = 1'b0;
  always @(posedge clk) begin
    tmr_exp <= 1'b0;
    if (sys_reset) begin
      tmr_run <= 1'b0;
      tmr_cnt <= 4'd0;
    end else if (start_timer) begin
      tmr_cnt <= timer_value;
      tmr_run <= 1'b1;
    end else if (tmr_run) begin
      if (tmr_cnt == 4'd1) begin
        tmr_exp <= 1'b1;
        tmr_run <= 1'b0;
      end else begin
        tmr_cnt <= tmr_cnt - 4'd1;
      end
    end
  end
  assign expired = tmr_exp | man_exp;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int last_entry_cyc = 0;
  logic [3:0] cur_val = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_main(state_e s);
    case (s)
      ST_MG1, ST_MG2: return 3'b001;
      ST_MY:          return 3'b010;
      default:        return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(state_e s);
    case (s)
      ST_SG1, ST_SG2: return 3'b001;
      ST_SY:          return 3'b010;
      default:        return 3'b100;
    endcase
  endfunction

  // At a negedge where a fresh entry into st is expected: check it, then
  // step one cycle and check the start pulse dropped and the value held.
  task automatic check_entry(input state_e st, input logic [3:0] val, input string tag);
    chk({tag, "_start"}, 32'(start_timer), 32'd1);
    chk({tag, "_state"}, 32'(dbg_state), 32'(st));
    chk({tag, "_tval"}, 32'(timer_value), 32'(val));
    chk({tag, "_main"}, 32'(main_light), 32'(exp_main(st)));
    chk({tag, "_side"}, 32'(side_light), 32'(exp_side(st)));
    chk({tag, "_walk"}, 32'(walk_lamp), (st == ST_WALK) ? 32'd1 : 32'd0);
    last_entry_cyc = cyc;
    cur_val = val;
    @(negedge clk);
    chk({tag, "_pulse1"}, 32'(start_timer), 32'd0);
    chk({tag, "_hold"}, 32'(timer_value), 32'(val));
  endtask

  // Wait (bounded) for the next start pulse and check the dwell length.
  task automatic wait_entry(input string tag);
    int n;
    n = 0;
    while (start_timer !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(start_timer), 32'd1);
    chk({tag, "_dwell"}, 32'(cyc - last_entry_cyc), 32'(cur_val) + 32'd2);
  endtask

  task automatic step(input state_e st, input logic [3:0] val, input string tag);
    wait_entry(tag);
    check_entry(st, val, tag);
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    reprogram = 1'b1;
    time_param_sel = sel;
    time_value = val;
    @(negedge clk);
    reprogram = 1'b0;
    time_param_sel = 2'd3;
    time_value = 4'd0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", 32'(start_timer), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_MG1));
    chk("rst_main", 32'(main_light), 32'b001);
    chk("rst_side", 32'(side_light), 32'b100);
    chk("rst_walk", 32'(walk_lamp), 32'd0);
    chk("rst_tval", 32'(timer_value), 32'd6);
    chk("rst_pend", 32'(dbg_walk_pend), 32'd0);
    sys_reset = 1'b0;
    @(negedge clk);
    check_entry(ST_MG1, 4'd6, "rel_mg1");

    // Sensor idle, no walk
    step(ST_MG2, 4'd6, "s0_mg2");
    step(ST_MY,  4'd2, "s0_my");
    step(ST_SG1, 4'd6, "s0_sg1");
    step(ST_SY,  4'd2, "s0_sy");
    step(ST_MG1, 4'd6, "s0_mg1");

    // Sensor held high: MG2 skipped, SG2 used
    sensor = 1'b1;
    step(ST_MY,  4'd2, "s1_my");
    step(ST_SG1, 4'd6, "s1_sg1");
    step(ST_SG2, 4'd3, "s1_sg2");
    step(ST_SY,  4'd2, "s1_sy");
    step(ST_MG1, 4'd6, "s1_mg1");

    // Walk request during MG1
    sensor = 1'b0;
    walk_push = 1'b1;
    @(negedge clk);
    walk_push = 1'b0;
    chk("walk_latched", 32'(dbg_walk_pend), 32'd1);
    step(ST_MG2,  4'd6, "w_mg2");
    step(ST_MY,   4'd2, "w_my");
    step(ST_WALK, 4'd3, "w_walk");
    chk("walk_cleared", 32'(dbg_walk_pend), 32'd0);
    step(ST_SG1,  4'd6, "w_sg1");
    step(ST_SY,   4'd2, "w_sy");
    step(ST_MG1,  4'd6, "w_mg1");

    // Reprogram base=9 in SG1 together with a stale-looking expired
    step(ST_MG2, 4'd6, "r_mg2");
    step(ST_MY,  4'd2, "r_my");
    step(ST_SG1, 4'd6, "r_sg1");
    @(negedge clk);
    man_exp = 1'b1;
    prog(2'd0, 4'd9);
    man_exp = 1'b0;
    check_entry(ST_MG1, 4'd9, "r_mg1");
    // Zero value and sel=3 are ignored
    prog(2'd0, 4'd0);
    chk("zero_nostart", 32'(start_timer), 32'd0);
    chk("zero_state", 32'(dbg_state), 32'(ST_MG1));
    chk("zero_tval", 32'(timer_value), 32'd9);
    prog(2'd3, 4'd5);
    chk("sel3_nostart", 32'(start_timer), 32'd0);
    chk("sel3_tval", 32'(timer_value), 32'd9);
    step(ST_MG2, 4'd9, "r9_mg2");
    // yel=1 from MG2 restarts at MG1 with base 9
    prog(2'd2, 4'd1);
    check_entry(ST_MG1, 4'd9, "ry_mg1");
    step(ST_MG2, 4'd9, "ry_mg2");
    step(ST_MY,  4'd1, "ry_my");
    step(ST_SG1, 4'd9, "ry_sg1");
    step(ST_SY,  4'd1, "ry_sy");
    step(ST_MG1, 4'd9, "ry_mg1b");

    // Reset in the middle of SG2 with a walk request pending
    sensor = 1'b1;
    step(ST_MY,  4'd1, "m_my");
    step(ST_SG1, 4'd9, "m_sg1");
    step(ST_SG2, 4'd3, "m_sg2");
    walk_push = 1'b1;
    @(negedge clk);
    walk_push = 1'b0;
    sys_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_start", 32'(start_timer), 32'd0);
    chk("mrst_state", 32'(dbg_state), 32'(ST_MG1));
    chk("mrst_main", 32'(main_light), 32'b001);
    chk("mrst_side", 32'(side_light), 32'b100);
    chk("mrst_walk", 32'(walk_lamp), 32'd0);
    chk("mrst_tval", 32'(timer_value), 32'd6);
    chk("mrst_pend", 32'(dbg_walk_pend), 32'd0);
    sys_reset = 1'b0;
    sensor = 1'b0;
    @(negedge clk);
    check_entry(ST_MG1, 4'd6, "mrel_mg1");

    // Stale expired in the start cycle of MG2
    wait_entry("st_mg2");
    man_exp = 1'b1;
    check_entry(ST_MG2, 4'd6, "st_mg2");
    man_exp = 1'b0;
    chk("stale_hold", 32'(dbg_state), 32'(ST_MG2));
    step(ST_MY, 4'd2, "st_my");
    chk("no_walk_left", 32'(dbg_walk_pend), 32'd0);
    step(ST_SG1, 4'd6, "st_sg1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
